gen_patt_multi: RTL and testbench
=================================

Name: gen_patt_multi

Overview:
- Parametrised, registered VGA test-pattern generator with four run-time selectable patterns: vertical bars, horizontal bars, checkerboard, and horizontally scrolling bars.
- Sits between the sync/timing generator, which supplies row, column and the active-video flag, and the RGB output pins.
- Mode changes take effect only at frame start, so a frame never tears.
- Keeps a frame counter and a per-frame scroll offset.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- COL_W, 10, width of column_i; must satisfy 2^COL_W >= H_ACTIVE.
- ROW_W, 10, width of row_i; must satisfy 2^ROW_W >= V_ACTIVE.
- NUM_BARS, 3, number of bars in the bar modes; range 1..16.
- CHECK_LOG2, 5, log2 of the checkerboard square size in pixels (32x32 by default).
- SCROLL_STEP, 1, pixels the scroll offset advances per frame; must be < H_ACTIVE.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk_i, in, 1, pixel clock.
- rst_ni, in, 1, reset, asynchronous, active-low.
- de_i, in, 1, active-video flag from the timing generator.
- row_i, in, ROW_W, current line, 0-based.
- column_i, in, COL_W, current pixel within the line, 0-based.
- mode_i, in, 2, pattern select: 0 = vertical bars, 1 = horizontal bars, 2 = checkerboard, 3 = scrolling vertical bars.
- color_a_i, in, 3, colour for even bars/squares, RGB = {R,G,B}.
- color_b_i, in, 3, colour for odd bars/squares.
- rgb_o, out, 3, registered pixel colour.
- de_o, out, 1, de_i delayed one cycle; aligned with rgb_o.
- frame_cnt_o, out, FCNT_W, number of frames started since reset.

Behaviour:
- Single clock domain; all state on clk_i rising edge.
- Asynchronous reset (rst_ni = 0) sets: rgb_o = 0, de_o = 0, frame_cnt_o = 0, mode_q = 0, offset_q = 0.
- Latency: rgb_o and de_o reflect the inputs of the previous cycle (1 cycle, fixed).

Blanking:
- If de_i = 0, or column_i >= H_ACTIVE, or row_i >= V_ACTIVE, then the next rgb_o = 3'b000.
- de_o always copies de_i, with no range check.

Frame start:
- fs = de_i & (row_i == 0) & (column_i == 0).
- On fs:
  - mode_q <= mode_i.
  - frame_cnt_o <= frame_cnt_o + 1, wrapping modulo 2^FCNT_W.
  - If mode_i == 3: offset_q <= (offset_q + SCROLL_STEP), minus H_ACTIVE if the sum is >= H_ACTIVE (one conditional subtract).
  - If mode_i != 3: offset_q <= 0.
- The fs pixel itself is computed with mode_i and the updated offset. All later pixels of that frame use mode_q and offset_q.
- A mode_i change mid-frame has no visible effect until the next fs.
- Before the first fs after reset, mode 0 with offset 0 applies.

Pattern rules (eff_mode and eff_offset are the values defined above):
- BAR_W = H_ACTIVE / NUM_BARS and BAR_H = V_ACTIVE / NUM_BARS, both integer constants.
- idx(p, W) = min(floor(p / W), NUM_BARS - 1). The last bar absorbs the remainder.
- Mode 0: sel = idx(column_i, BAR_W)[0].
- Mode 1: sel = idx(row_i, BAR_H)[0].
- Mode 2: sel = column_i[CHECK_LOG2] ^ row_i[CHECK_LOG2].
- Mode 3:
  - x = column_i + eff_offset, minus H_ACTIVE if x >= H_ACTIVE.
  - sel = idx(x, BAR_W)[0].
- Output: rgb_o = sel ? color_b_i : color_a_i.
- color_a_i and color_b_i are sampled every cycle, not latched per frame.

Boundaries:
- NUM_BARS = 1: every active pixel is color_a_i in modes 0, 1 and 3.
- frame_cnt_o wraps from all-ones to 0 with no flag.
- rst_ni asserted mid-line: outputs clear immediately. After release, behaviour resumes at the next clock edge in mode 0 until an fs occurs.
- Arithmetic widths: the mode-3 sum is computed at COL_W+1 bits so the wrap never overflows.
- No division hardware required: idx is a comparator chain against the constant multiples k*BAR_W and k*BAR_H.

Test Plan:
- Reset: hold rst_ni = 0 with de_i = 1 -> rgb_o = 0, de_o = 0, frame_cnt_o = 0; release -> first output appears one cycle after the first clock edge.
- Mode 0, defaults, color_a = 010, color_b = 100, row 5 -> column 0 and 212 give 010; column 213 and 425 give 100; column 426 and 639 give 010; all one cycle delayed.
- Mode 2, CHECK_LOG2 = 5 -> (col 31, row 0) = color_a; (col 32, row 0) = color_b; (col 32, row 32) = color_a.
- Mode 3, SCROLL_STEP = 1, over 3 frames -> offset_q after each fs = 1, 2, 3; in frame 3, column 210 gives color_b (x = 213); frame_cnt_o = 3.
- Mode 3 wrap: SCROLL_STEP = 100, run 7 frames -> offsets 100..600, then 60 (700 - 640).
- Mid-frame mode_i change from 0 to 1 at row 100 -> pattern stays mode 0 until the next fs. Blanking checks: de_i = 0 or column_i = 700 -> rgb_o = 0.

Source files
------------

// File: rtl/gen_patt_multi.sv
// Registered VGA test-pattern generator: vertical/horizontal bars, checkerboard
// and scrolling bars, with mode and scroll offset captured at frame start.
module gen_patt_multi #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned COL_W       = 10,
  parameter int unsigned ROW_W       = 10,
  parameter int unsigned NUM_BARS    = 3,
  parameter int unsigned CHECK_LOG2  = 5,
  parameter int unsigned SCROLL_STEP = 1,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              de_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [COL_W-1:0]  column_i,
  input  logic [1:0]        mode_i,
  input  logic [2:0]        color_a_i,
  input  logic [2:0]        color_b_i,
  output logic [2:0]        rgb_o,
  output logic              de_o,
  output logic [FCNT_W-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    MODE_VBAR   = 2'd0,
    MODE_HBAR   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;
  localparam int unsigned BAR_H = V_ACTIVE / NUM_BARS;
  // One extra bit so column + offset cannot overflow before the wrap.
  localparam int unsigned OW = COL_W + 1;
  localparam logic [OW-1:0] H_OW    = (OW)'(H_ACTIVE);
  localparam logic [OW-1:0] STEP_OW = (OW)'(SCROLL_STEP);

  // Parity of min(p / w, NUM_BARS-1), built as a compare chain against k*w.
  function automatic logic bar_sel(input logic [31:0] p, input int unsigned w);
    logic par;
    par = 1'b0;
    for (int unsigned k = 1; k < NUM_BARS; k++) begin
      if (p >= k * w) par = k[0];
    end
    return par;
  endfunction

  mode_e          mode_q;
  mode_e          mode_in;
  mode_e          eff_mode;
  logic [OW-1:0]  offset_q;
  logic [OW-1:0]  offset_step;
  logic [OW-1:0]  offset_next;
  logic [OW-1:0]  eff_offset;
  logic [OW-1:0]  x_sum;
  logic [OW-1:0]  x_wrap;
  logic           fs;
  logic           active;
  logic           sel;

  assign fs      = de_i && (row_i == '0) && (column_i == '0);
  assign mode_in = mode_e'(mode_i);
  assign active  = de_i && (32'(column_i) < H_ACTIVE) && (32'(row_i) < V_ACTIVE);

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    offset_step = offset_q + STEP_OW;
    offset_next = (offset_step >= H_OW) ? offset_step - H_OW : offset_step;
    eff_mode    = mode_q;
    eff_offset  = offset_q;
    sel         = 1'b0;

    // The frame-start pixel already uses the newly captured mode and offset.
    if (fs) begin
      eff_mode   = mode_in;
      eff_offset = (mode_in == MODE_SCROLL) ? offset_next : '0;
    end

    x_sum  = {1'b0, column_i} + eff_offset;
    x_wrap = (x_sum >= H_OW) ? x_sum - H_OW : x_sum;

    unique case (eff_mode)
      MODE_VBAR:   sel = bar_sel(32'(column_i), BAR_W);
      MODE_HBAR:   sel = bar_sel(32'(row_i), BAR_H);
      MODE_CHECK:  sel = column_i[CHECK_LOG2] ^ row_i[CHECK_LOG2];
      MODE_SCROLL: sel = bar_sel(32'(x_wrap), BAR_W);
      default:     sel = 1'b0;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_o       <= '0;
      de_o        <= 1'b0;
      frame_cnt_o <= '0;
      mode_q      <= MODE_VBAR;
      offset_q    <= '0;
    end else begin
      de_o  <= de_i;
      rgb_o <= active ? (sel ? color_b_i : color_a_i) : 3'b000;
      if (fs) begin
        mode_q      <= mode_in;
        frame_cnt_o <= frame_cnt_o + (FCNT_W)'(1);
        offset_q    <= (mode_in == MODE_SCROLL) ? offset_next : '0;
      end
    end
  end

endmodule

// File: tb/tb_gen_patt_multi.sv
// Self-checking bench for gen_patt_multi: three parameter sets driven in
// parallel and compared against an arithmetic reference model.
module tb_gen_patt_multi;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       de_i;
  logic [9:0] row_i;
  logic [9:0] column_i;
  logic [1:0] mode_i;
  logic [2:0] color_a_i;
  logic [2:0] color_b_i;

  logic [2:0]  obs_rgb [3];
  logic        obs_de  [3];
  logic [15:0] fc0;
  logic [15:0] fc1;
  logic [2:0]  fc2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state and per-instance parameters.
  int m_mode [3];
  int m_off  [3];
  int m_fcnt [3];
  int p_step [3] = '{1, 100, 1};
  int p_nb   [3] = '{3, 3, 1};
  int p_fw   [3] = '{16, 16, 3};

  always #5 clk_i = ~clk_i;

  gen_patt_multi dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .de_i(de_i), .row_i(row_i), .column_i(column_i),
    .mode_i(mode_i), .color_a_i(color_a_i), .color_b_i(color_b_i),
    .rgb_o(obs_rgb[0]), .de_o(obs_de[0]), .frame_cnt_o(fc0)
  );

  gen_patt_multi #(.SCROLL_STEP(100)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .de_i(de_i), .row_i(row_i), .column_i(column_i),
    .mode_i(mode_i), .color_a_i(color_a_i), .color_b_i(color_b_i),
    .rgb_o(obs_rgb[1]), .de_o(obs_de[1]), .frame_cnt_o(fc1)
  );

  gen_patt_multi #(.NUM_BARS(1), .FCNT_W(3)) dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .de_i(de_i), .row_i(row_i), .column_i(column_i),
    .mode_i(mode_i), .color_a_i(color_a_i), .color_b_i(color_b_i),
    .rgb_o(obs_rgb[2]), .de_o(obs_de[2]), .frame_cnt_o(fc2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_fc(input int d);
    case (d)
      0:       return 32'(fc0);
      1:       return 32'(fc1);
      default: return 32'(fc2);
    endcase
  endfunction

  function automatic logic [2:0] model_pix(input int nb, input int em, input int eo,
                                           input logic de, input int row, input int col,
                                           input logic [2:0] ca, input logic [2:0] cb);
    int bw;
    int bh;
    int i;
    int s;
    bw = 640 / nb;
    bh = 480 / nb;
    if (!de || col >= 640 || row >= 480) return 3'b000;
    case (em)
      0:       i = col / bw;
      1:       i = row / bh;
      3:       i = ((col + eo) % 640) / bw;
      default: i = 0;
    endcase
    if (i > nb - 1) i = nb - 1;
    if (em == 2) s = ((col / 32) + (row / 32)) % 2;
    else         s = i % 2;
    return (s != 0) ? cb : ca;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_mode[d] = 0;
      m_off[d]  = 0;
      m_fcnt[d] = 0;
    end
  endtask

  // Drive one pixel, advance the model, then check all three instances after the edge.
  task automatic apply(input logic de, input int row, input int col, input int mode,
                       input logic [2:0] ca, input logic [2:0] cb);
    logic [2:0] exp_rgb [3];
    de_i      = de;
    row_i     = row[9:0];
    column_i  = col[9:0];
    mode_i    = mode[1:0];
    color_a_i = ca;
    color_b_i = cb;
    for (int d = 0; d < 3; d++) begin
      if (de && row == 0 && col == 0) begin
        m_fcnt[d] = (m_fcnt[d] + 1) % (1 << p_fw[d]);
        m_mode[d] = mode;
        m_off[d]  = (mode == 3) ? (m_off[d] + p_step[d]) % 640 : 0;
      end
      exp_rgb[d] = model_pix(p_nb[d], m_mode[d], m_off[d], de, row, col, ca, cb);
    end
    @(posedge clk_i);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_rgb r%0d c%0d", d, row, col), 32'(obs_rgb[d]), 32'(exp_rgb[d]));
      check($sformatf("d%0d_de", d), 32'(obs_de[d]), 32'(de));
      check($sformatf("d%0d_fcnt", d), obs_fc(d), 32'(m_fcnt[d]));
    end
  endtask

  task automatic reset_pulse();
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni    = 1'b0;
    de_i      = 1'b1;
    row_i     = 10'd5;
    column_i  = 10'd0;
    mode_i    = 2'd0;
    color_a_i = 3'b010;
    color_b_i = 3'b100;
    model_reset();

    // Reset held with de_i high: outputs stay cleared.
    repeat (2) @(posedge clk_i);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_rgb%0d", d), 32'(obs_rgb[d]), 32'd0);
      check($sformatf("rst_de%0d", d), 32'(obs_de[d]), 32'd0);
      check($sformatf("rst_fcnt%0d", d), obs_fc(d), 32'd0);
    end
    rst_ni = 1'b1;

    // Mode 0 before any frame start, bar boundaries at 213 and 426.
    apply(1'b1, 5, 0,   1, 3'b010, 3'b100); check("m0_c0",   32'(obs_rgb[0]), 32'b010);
    apply(1'b1, 5, 212, 1, 3'b010, 3'b100); check("m0_c212", 32'(obs_rgb[0]), 32'b010);
    apply(1'b1, 5, 213, 1, 3'b010, 3'b100); check("m0_c213", 32'(obs_rgb[0]), 32'b100);
    apply(1'b1, 5, 425, 1, 3'b010, 3'b100); check("m0_c425", 32'(obs_rgb[0]), 32'b100);
    apply(1'b1, 5, 426, 1, 3'b010, 3'b100); check("m0_c426", 32'(obs_rgb[0]), 32'b010);
    apply(1'b1, 5, 639, 1, 3'b010, 3'b100); check("m0_c639", 32'(obs_rgb[0]), 32'b010);

    // Checkerboard.
    apply(1'b1, 0, 0,   2, 3'b010, 3'b100); check("ck_fs",   32'(obs_rgb[0]), 32'b010);
    apply(1'b1, 0, 31,  0, 3'b010, 3'b100); check("ck_31_0", 32'(obs_rgb[0]), 32'b010);
    apply(1'b1, 0, 32,  0, 3'b010, 3'b100); check("ck_32_0", 32'(obs_rgb[0]), 32'b100);
    apply(1'b1, 32, 32, 0, 3'b010, 3'b100); check("ck_32_32", 32'(obs_rgb[0]), 32'b010);

    // Scrolling over seven frames; step 100 instance wraps 600 -> 60.
    reset_pulse();
    for (int f = 1; f <= 7; f++) begin
      apply(1'b1, 0, 0,   3, 3'b010, 3'b100);
      apply(1'b1, 5, 153, 3, 3'b010, 3'b100);
      apply(1'b1, 5, 210, 3, 3'b010, 3'b100);
      if (f == 3) begin
        check("sc_f3_c210", 32'(obs_rgb[0]), 32'b100);
        check("sc_f3_fcnt", 32'(fc0), 32'd3);
      end
      apply(1'b1, 5, 253, 3, 3'b010, 3'b100);
      if (f == 6) check("sc_off600_c253", 32'(obs_rgb[1]), 32'b100);
    end
    apply(1'b1, 5, 153, 3, 3'b010, 3'b100);
    check("sc_off60_c153", 32'(obs_rgb[1]), 32'b100);

    // Mid-frame mode change is ignored until the next frame start.
    apply(1'b1, 0, 0,     0, 3'b010, 3'b100);
    apply(1'b1, 100, 300, 1, 3'b010, 3'b100); check("mid_mode", 32'(obs_rgb[0]), 32'b100);
    apply(1'b1, 0, 0,     1, 3'b010, 3'b100);
    apply(1'b1, 100, 300, 0, 3'b010, 3'b100); check("new_mode", 32'(obs_rgb[0]), 32'b010);

    // Blanking.
    apply(1'b0, 10, 10,  1, 3'b111, 3'b111); check("blank_de",  32'(obs_rgb[0]), 32'd0);
    apply(1'b1, 10, 700, 1, 3'b111, 3'b111); check("blank_col", 32'(obs_rgb[0]), 32'd0);
    apply(1'b1, 500, 10, 1, 3'b111, 3'b111); check("blank_row", 32'(obs_rgb[0]), 32'd0);

    // Asynchronous reset mid-line clears outputs without a clock edge.
    apply(1'b1, 7, 300, 1, 3'b101, 3'b011);
    rst_ni = 1'b0;
    #1;
    check("async_rgb",  32'(obs_rgb[0]), 32'd0);
    check("async_de",   32'(obs_de[0]), 32'd0);
    check("async_fcnt", 32'(fc0), 32'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    apply(1'b1, 7, 300, 2, 3'b101, 3'b011); check("post_rst_m0", 32'(obs_rgb[0]), 32'b011);

    // Randomised frames, mid-frame mode changes and blanking.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(15) == 0) begin
        apply(1'b1, 0, 0, int'($urandom_range(3)), 3'($urandom), 3'($urandom));
      end else begin
        apply($urandom_range(9) != 0, int'($urandom_range(520)), int'($urandom_range(700)),
              int'($urandom_range(3)), 3'($urandom), 3'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
